// File: rtl/gpio_apb_ctrl.sv
// gpio_apb_ctrl: APB slave that sequences a bank of NPINS GPIO cells.
// It keeps TRIS/PORT shadows for readback, strobes the cell flops on writes,
// gates the per-pin read latches for PIN reads and for a background poll,
// and raises a level interrupt on rising edges seen between samples.
module gpio_apb_ctrl #(
  parameter int NPINS  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NPINS-1:0]  gpio_wr_tris,
  output logic [NPINS-1:0]  gpio_wr_port,
  output logic [NPINS-1:0]  gpio_wdata,
  output logic [NPINS-1:0]  gpio_rd_port,
  input  logic [NPINS-1:0]  gpio_rdata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] OFF_TRIS     = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_PORT     = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFF_PIN      = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFF_IRQ_EN   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] OFF_IRQ_STAT = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] OFF_POLL_DIV = ADDR_W'(8'h14);

  typedef enum logic [2:0] {
    IDLE,
    POLL1,
    POLL2,
    RD1,
    RD2
  } state_t;

  state_t state_q, state_d;

  logic [NPINS-1:0] tris_q, port_q, irq_en_q, irq_stat_q, sample_q;
  logic [NPINS-1:0] irq_stat_d, rise, w1c_mask;
  logic [15:0]      poll_div_q, poll_cnt_q, poll_cnt_d;

  logic access;
  logic sel_tris, sel_port, sel_pin, sel_irq_en, sel_irq_stat, sel_poll_div, mapped;
  logic pready_c, pslverr_c;
  logic wr_tris_c, wr_port_c, wr_irq_en_c, w1c_c, wr_poll_div_c;
  logic rd_port_c, sample_load_c;
  logic [31:0] prdata_c, rd_mux;
  logic unused_pwdata;

  // Widen a pin-wide value to the 32-bit bus with zeros above NPINS.
  function automatic logic [31:0] zext(input logic [NPINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NPINS-1:0] = v;
    return r;
  endfunction

  assign access       = PSEL & PENABLE;
  assign sel_tris     = (PADDR == OFF_TRIS);
  assign sel_port     = (PADDR == OFF_PORT);
  assign sel_pin      = (PADDR == OFF_PIN);
  assign sel_irq_en   = (PADDR == OFF_IRQ_EN);
  assign sel_irq_stat = (PADDR == OFF_IRQ_STAT);
  assign sel_poll_div = (PADDR == OFF_POLL_DIV);
  assign mapped       = sel_tris | sel_port | sel_pin | sel_irq_en | sel_irq_stat | sel_poll_div;

  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign unused_pwdata = ^PWDATA;

  // Readback mux for the zero-wait registers.
  always_comb begin
    rd_mux = '0;
    if (sel_tris)          rd_mux = zext(tris_q);
    else if (sel_port)     rd_mux = zext(port_q);
    else if (sel_irq_en)   rd_mux = zext(irq_en_q);
    else if (sel_irq_stat) rd_mux = zext(irq_stat_q);
    else if (sel_poll_div) rd_mux = {16'h0000, poll_div_q};
  end

  // FSM state register; reset lands in IDLE with nothing in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, bus response, cell strobes and poll-counter update.
  always_comb begin
    state_d       = state_q;
    poll_cnt_d    = poll_cnt_q;
    pready_c      = 1'b0;
    pslverr_c     = 1'b0;
    prdata_c      = '0;
    wr_tris_c     = 1'b0;
    wr_port_c     = 1'b0;
    wr_irq_en_c   = 1'b0;
    w1c_c         = 1'b0;
    wr_poll_div_c = 1'b0;
    rd_port_c     = 1'b0;
    sample_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!PWRITE && sel_pin) begin
            rd_port_c = 1'b1;
            state_d   = RD1;
          end else begin
            pready_c = 1'b1;
            if (!mapped || (PWRITE && sel_pin)) begin
              pslverr_c = 1'b1;
            end else if (PWRITE) begin
              wr_tris_c     = sel_tris;
              wr_port_c     = sel_port;
              wr_irq_en_c   = sel_irq_en;
              w1c_c         = sel_irq_stat;
              wr_poll_div_c = sel_poll_div;
            end else begin
              prdata_c = rd_mux;
            end
          end
        end
        if (poll_div_q != 16'd0) begin
          if (poll_cnt_q == poll_div_q - 16'd1) begin
            if (!PSEL) begin
              poll_cnt_d = '0;
              state_d    = POLL1;
            end
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
        end
        if (wr_poll_div_c) poll_cnt_d = '0;
      end
      POLL1: begin
        rd_port_c = 1'b1;
        state_d   = POLL2;
      end
      POLL2: begin
        rd_port_c     = 1'b1;
        sample_load_c = 1'b1;
        state_d       = IDLE;
      end
      RD1: begin
        rd_port_c     = 1'b1;
        pready_c      = 1'b1;
        prdata_c      = zext(gpio_rdata);
        sample_load_c = 1'b1;
        state_d       = RD2;
      end
      RD2: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Edge detection: a new rising edge wins over a clear of the same bit.
  always_comb begin
    w1c_mask   = w1c_c ? PWDATA[NPINS-1:0] : '0;
    rise       = sample_load_c ? (gpio_rdata & ~sample_q) : '0;
    irq_stat_d = (irq_stat_q & ~w1c_mask) | rise;
  end

  // Software-visible registers, pin sample and poll counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tris_q     <= '1;
      port_q     <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      sample_q   <= '0;
      poll_div_q <= '0;
      poll_cnt_q <= '0;
    end else begin
      if (wr_tris_c)     tris_q     <= PWDATA[NPINS-1:0];
      if (wr_port_c)     port_q     <= PWDATA[NPINS-1:0];
      if (wr_irq_en_c)   irq_en_q   <= PWDATA[NPINS-1:0];
      if (wr_poll_div_c) poll_div_q <= PWDATA[15:0];
      if (sample_load_c) sample_q   <= gpio_rdata;
      irq_stat_q <= irq_stat_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, even with a bus access present.
  assign PREADY       = pready_c & PRESETn;
  assign PSLVERR      = pslverr_c & PRESETn;
  assign PRDATA       = PRESETn ? prdata_c : '0;
  assign gpio_wr_tris = {NPINS{wr_tris_c & PRESETn}};
  assign gpio_wr_port = {NPINS{wr_port_c & PRESETn}};
  assign gpio_wdata   = ((wr_tris_c | wr_port_c) & PRESETn) ? PWDATA[NPINS-1:0] : '0;
  assign gpio_rd_port = {NPINS{rd_port_c & PRESETn}};
  assign irq          = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// tb_gpio_apb_ctrl: scoreboard bench for gpio_apb_ctrl with a register-level
// reference model of the GPIO block and a separate bus monitor.
module tb_gpio_apb_ctrl;

  localparam int NPINS  = 8;
  localparam int ADDR_W = 5;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [ADDR_W-1:0] PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NPINS-1:0]  gpio_wr_tris, gpio_wr_port, gpio_wdata, gpio_rd_port, gpio_rdata;
  logic              irq;

  logic [7:0] pins = 8'h00;

  gpio_apb_ctrl #(.NPINS(NPINS), .ADDR_W(ADDR_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_wr_tris(gpio_wr_tris),
    .gpio_wr_port(gpio_wr_port), .gpio_wdata(gpio_wdata),
    .gpio_rd_port(gpio_rd_port), .gpio_rdata(gpio_rdata), .irq(irq)
  );

  // Read buffers only drive the bus while their enable is on.
  assign gpio_rdata = (gpio_rd_port == 8'hFF) ? pins : 8'h00;

  always #5 PCLK = ~PCLK;

  typedef struct {
    string      name;
    logic [31:0] data;
    logic        err;
    int          waits;
    int          rd;
    logic [7:0]  wr_tris;
    logic [7:0]  wr_port;
    logic [7:0]  wdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_tris, m_port, m_irq_en, m_irq_stat, m_sample;
  logic [15:0] m_poll_div;

  task automatic model_reset();
    m_tris = 8'hFF; m_port = 8'h00; m_irq_en = 8'h00;
    m_irq_stat = 8'h00; m_sample = 8'h00; m_poll_div = 16'h0000;
  endtask

  // A pin sample records every bit that went 0 -> 1 since the previous sample.
  function automatic void model_sample();
    m_irq_stat = m_irq_stat | (pins & ~m_sample);
    m_sample = pins;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic checkIrq(input string name);
    checkOutput(name, {31'b0, irq}, {31'b0, |(m_irq_stat & m_irq_en)});
  endtask

  function automatic exp_t blank_exp(input string name);
    exp_t e;
    e.name = name; e.data = 0; e.err = 0; e.waits = 0; e.rd = 0;
    e.wr_tris = 0; e.wr_port = 0; e.wdata = 0;
    return e;
  endfunction

  task automatic wait_ready(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (PREADY) begin done = 1; break; end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s timeout: PREADY never rose, required within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
  endtask

  // One APB transfer; expectation comes from the model before the bus moves.
  task automatic applyStimulus(input bit wr, input logic [4:0] addr, input logic [31:0] data, input bit dc_timing);
    exp_t e;
    e = blank_exp($sformatf("%s@%02h", wr ? "wr" : "rd", addr));
    case (addr)
      5'h00: if (wr) begin e.wr_tris = 8'hFF; e.wdata = data[7:0]; m_tris = data[7:0]; end
             else e.data = {24'h0, m_tris};
      5'h04: if (wr) begin e.wr_port = 8'hFF; e.wdata = data[7:0]; m_port = data[7:0]; end
             else e.data = {24'h0, m_port};
      5'h08: if (wr) e.err = 1;
             else begin e.waits = 1; e.rd = 2; e.data = {24'h0, pins}; model_sample(); end
      5'h0C: if (wr) m_irq_en = data[7:0]; else e.data = {24'h0, m_irq_en};
      5'h10: if (wr) m_irq_stat = m_irq_stat & ~data[7:0]; else e.data = {24'h0, m_irq_stat};
      5'h14: if (wr) m_poll_div = data[15:0]; else e.data = {16'h0, m_poll_div};
      default: e.err = 1;
    endcase
    if (dc_timing) begin e.waits = -1; e.rd = -1; end
    sb.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1;
    wait_ready(e.name);
  endtask

  // Monitor: accumulates what the DUT shows during each access and checks it at PREADY.
  int acc_waits = 0, acc_rd = 0;
  logic [7:0] acc_wt = 0, acc_wp = 0, acc_wd = 0;
  bit acc_prnz = 0, stray = 0;

  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        acc_waits = 0; acc_rd = 0; acc_wt = 0; acc_wp = 0; acc_wd = 0; acc_prnz = 0; stray = 0;
      end else if (PSEL && PENABLE) begin
        if (gpio_rd_port == 8'hFF) acc_rd++;
        acc_wt = acc_wt | gpio_wr_tris;
        acc_wp = acc_wp | gpio_wr_port;
        if ((gpio_wr_tris | gpio_wr_port) != 0) acc_wd = gpio_wdata;
        if (!PREADY) begin
          acc_waits++;
          if (PRDATA != 0) acc_prnz = 1;
        end else begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected PREADY: got data %08h, required no transfer", PRDATA);
          end else begin
            e = sb.pop_front();
            ok = (PRDATA === e.data) && (PSLVERR === e.err) &&
                 (e.waits < 0 || acc_waits == e.waits) && (e.rd < 0 || acc_rd == e.rd) &&
                 (acc_wt === e.wr_tris) && (acc_wp === e.wr_port) && (acc_wd === e.wdata) &&
                 !acc_prnz && !stray;
            if (!ok) begin
              miscompares++;
              $display("[TB] FAIL %s: got data=%08h err=%0b waits=%0d rd=%0d wt=%02h wp=%02h wd=%02h prnz=%0b stray=%0b; required data=%08h err=%0b waits=%0d rd=%0d wt=%02h wp=%02h wd=%02h",
                       e.name, PRDATA, PSLVERR, acc_waits, acc_rd, acc_wt, acc_wp, acc_wd, acc_prnz, stray,
                       e.data, e.err, e.waits, e.rd, e.wr_tris, e.wr_port, e.wdata);
            end
          end
          acc_waits = 0; acc_rd = 0; acc_wt = 0; acc_wp = 0; acc_wd = 0; acc_prnz = 0; stray = 0;
        end
      end else if ((gpio_wr_tris | gpio_wr_port) != 0) begin
        stray = 1;
      end
    end
  end

  // Wait until a background poll has completed (bounded).
  task automatic wait_poll(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (gpio_rd_port == 8'hFF && !PSEL) begin found = 1; break; end
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s: no poll seen, required one within 60 cycles", name);
    end
    repeat (2) @(negedge PCLK);
  endtask

  // Access phase raised in the middle of POLL1; must stall until the poll ends.
  task automatic collide_read();
    exp_t e;
    bit prev, found;
    prev = 1; found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (gpio_rd_port == 8'hFF && !prev && !PSEL) begin found = 1; break; end
      prev = (gpio_rd_port == 8'hFF);
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("[TB] FAIL collide: no POLL1 seen, required one within 60 cycles");
    end else begin
      e = blank_exp("collide rd@00");
      e.data = {24'h0, m_tris}; e.waits = 1; e.rd = 1;
      sb.push_back(e);
      #1;
      PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 5'h00;
      wait_ready(e.name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int r;
    logic [4:0] a;
    model_reset();

    // Reset with a write access on the bus: nothing may leak out.
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 5'h04; PWDATA = 32'hFF;
    repeat (3) @(negedge PCLK);
    checkOutput("reset PREADY", {31'b0, PREADY}, 0);
    checkOutput("reset wr_port", {24'b0, gpio_wr_port}, 0);
    checkOutput("reset wr_tris", {24'b0, gpio_wr_tris}, 0);
    checkOutput("reset rd_port", {24'b0, gpio_rd_port}, 0);
    checkOutput("reset PRDATA", PRDATA, 0);
    checkIrq("reset irq");
    PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
    @(negedge PCLK);
    PRESETn = 1;

    $display("[TB] register reset values and basic writes");
    applyStimulus(0, 5'h00, 0, 0);
    applyStimulus(0, 5'h04, 0, 0);
    applyStimulus(1, 5'h04, 32'h0000_00A5, 0);
    applyStimulus(1, 5'h00, 32'hFFFF_FF0F, 0);
    applyStimulus(0, 5'h04, 0, 0);
    applyStimulus(0, 5'h00, 0, 0);

    $display("[TB] PIN read and errors");
    pins = 8'h3C;
    applyStimulus(0, 5'h08, 0, 0);
    checkIrq("irq after pin read");
    applyStimulus(1, 5'h08, 32'h55, 0);
    applyStimulus(0, 5'h18, 0, 0);
    applyStimulus(1, 5'h1C, 32'h12, 0);
    applyStimulus(0, 5'h04, 0, 0);
    applyStimulus(1, 5'h14, 32'hABCD_1234, 0);
    applyStimulus(0, 5'h14, 0, 0);
    applyStimulus(1, 5'h14, 32'h0, 0);

    $display("[TB] randomized register traffic");
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: applyStimulus(1, 5'h00, $urandom, 0);
        1: applyStimulus(1, 5'h04, $urandom, 0);
        2: applyStimulus(1, 5'h0C, $urandom, 0);
        3: applyStimulus(1, 5'h10, $urandom, 0);
        4, 5: begin pins = 8'($urandom); applyStimulus(0, 5'h08, 0, 0); end
        6: begin
          a = 5'(4 * $urandom_range(0, 5));
          if (a == 5'h08) a = 5'h0C;
          applyStimulus(0, a, 0, 0);
        end
        7: begin
          if ($urandom_range(0, 1) == 0) applyStimulus(1, 5'h08, $urandom, 0);
          else applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 1) ? 5'h18 : 5'h1C), $urandom, 0);
        end
        8: applyStimulus(0, 5'h00, 0, 0);
        default: applyStimulus(0, 5'h10, 0, 0);
      endcase
      checkIrq("irq random");
    end

    $display("[TB] background poll and interrupt");
    pins = 8'h00;
    applyStimulus(0, 5'h08, 0, 0);
    applyStimulus(1, 5'h10, 32'hFF, 0);
    applyStimulus(1, 5'h0C, 32'h01, 0);
    checkOutput("irq cleared", {31'b0, irq}, 0);
    pins = 8'h01;
    applyStimulus(1, 5'h14, 32'd4, 0);
    wait_poll("poll edge");
    model_sample();
    checkOutput("irq after poll", {31'b0, irq}, 1);
    applyStimulus(0, 5'h10, 0, 1);
    applyStimulus(1, 5'h10, 32'h01, 1);
    checkOutput("irq after w1c", {31'b0, irq}, 0);
    repeat (12) @(negedge PCLK);
    checkIrq("irq stays low");
    collide_read();

    $display("[TB] POLL_DIV=1 cadence");
    applyStimulus(1, 5'h14, 32'd1, 1);
    n = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (gpio_rd_port == 8'hFF) n++;
    end
    checkOutput("poll cadence", n, 20);
    applyStimulus(1, 5'h14, 32'd0, 1);
    applyStimulus(0, 5'h14, 0, 0);

    $display("[TB] reset during RD1");
    pins = 8'hC3;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 5'h08;
    @(posedge PCLK); #1;
    PENABLE = 1;
    @(posedge PCLK); #2;
    PRESETn = 0;
    #1;
    checkOutput("rst RD1 PREADY", {31'b0, PREADY}, 0);
    checkOutput("rst RD1 rd_port", {24'b0, gpio_rd_port}, 0);
    PSEL = 0; PENABLE = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1;
    model_reset();
    applyStimulus(0, 5'h00, 0, 0);
    applyStimulus(0, 5'h0C, 0, 0);
    applyStimulus(0, 5'h08, 0, 0);
    applyStimulus(0, 5'h10, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge PCLK);
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_apb_ctrl.md
Name: gpio_apb_ctrl

Overview:
- APB slave controller that sequences a bank of NPINS single-bit GPIO cells: TRIS flop, PORT flop, RD_PORT-gated read latch and tri-state read buffer per pin.
- Generates per-pin write-enable and read strobes, and keeps shadow copies of TRIS and PORT for readback.
- Runs a background poll of the pin latches to detect rising edges and raise a level interrupt.
- Sits between the SoC APB bus and the GPIO bank.

Parameters:
- NPINS, 8, number of GPIO cells controlled (1..32)
- ADDR_W, 5, width of PADDR (byte address, word aligned)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid when PREADY=1
- gpio_wr_tris  out  NPINS  per-pin TRIS flop enable
- gpio_wr_port  out  NPINS  per-pin PORT flop enable
- gpio_wdata  out  NPINS  per-pin data to TRIS/PORT flops
- gpio_rd_port  out  NPINS  per-pin read-latch enable / read-buffer enable
- gpio_rdata  in  NPINS  per-pin read-buffer outputs (valid only while rd_port=1)
- irq  out  1  interrupt, = |(IRQ_STAT & IRQ_EN)

Behaviour:
- Register map (offset):
  - 0x00 TRIS, RW, reset all 1 (1 = input).
  - 0x04 PORT, RW, reset 0.
  - 0x08 PIN, RO.
  - 0x0C IRQ_EN, RW, reset 0.
  - 0x10 IRQ_STAT, R/W1C, reset 0.
  - 0x14 POLL_DIV, RW, 16 bits, reset 0 (0 = polling off).
- Register width rules: bits above NPINS read 0 and ignore writes. GPIO cell flops reset to TRIS=1 and PORT=0, matching the shadows.
- Reset values of outputs: PRDATA=0, PREADY=0, PSLVERR=0, all gpio_* strobes 0, irq=0, state IDLE, poll counter=0.
- FSM states: IDLE, POLL1, POLL2, RD1, RD2.
- Write (PSEL&PENABLE&PWRITE) in IDLE:
  - Zero wait: PREADY=1 in the same cycle.
  - TRIS/PORT write: the matching gpio_wr_* is all-ones for exactly that cycle, gpio_wdata=PWDATA[NPINS-1:0], shadow updated on the same edge.
- Read of TRIS, PORT, IRQ_EN, IRQ_STAT or POLL_DIV in IDLE: zero wait. PRDATA is driven combinationally from the shadow/register while PREADY=1, and is 0 otherwise.
- PIN read:
  - IDLE -> RD1: gpio_rd_port all 1, PREADY=0.
  - RD1 -> RD2: rd_port held, PREADY=1, PRDATA=gpio_rdata.
  - RD2 -> IDLE. Total of one wait state.
  - The RD2 sample also loads sample_q and runs edge detection.
- Errors: unmapped offset, or write to 0x08 -> PREADY=1, PSLVERR=1, no state change, PRDATA=0.
- Polling:
  - In IDLE with POLL_DIV!=0, the counter increments each cycle.
  - When counter==POLL_DIV-1 and PSEL=0: counter clears and the FSM goes IDLE -> POLL1 -> POLL2 -> IDLE, with rd_port all 1 in both POLL states.
  - POLL2 captures gpio_rdata into sample_q.
  - If PSEL=1 at the terminal count, the poll is skipped and the counter holds at terminal until PSEL=0.
- Bus vs poll collision: an APB access phase arriving in POLL1/POLL2 sees PREADY=0. It is serviced from IDLE after POLL2, with normal timing from there.
- Edge detect: on every sample_q update, IRQ_STAT |= new & ~sample_q. Set has priority over a simultaneous W1C of the same bit.
- Polling restart: writing POLL_DIV clears the counter. POLL_DIV=1 means a poll every 3 cycles (IDLE, POLL1, POLL2).
- Reset mid-operation: reset forces IDLE, drops all strobes and PREADY immediately, and reloads all registers.
- sample_q resets to 0, so a pin held high gives a rising edge on the first sample after reset; software clears it.

Test Plan:
- Reset, then read 0x00 and 0x04 -> 0x000000FF and 0; no strobes seen during reset.
- Write 0x04=0xA5 then 0x00=0x0F:
  - gpio_wr_port=0xFF for one cycle with gpio_wdata=0xA5.
  - Then gpio_wr_tris=0xFF with wdata=0x0F.
  - Readback gives 0xA5 and 0x0F.
- Pins driven 0x3C, read 0x08 -> one wait state; rd_port high for 2 cycles; PRDATA=0x3C with PREADY=1.
- POLL_DIV=4, IRQ_EN=0x01, pin0 0->1:
  - IRQ_STAT bit0 set after the next POLL2 and irq=1.
  - Write 0x10=0x01 -> irq=0.
  - W1C coinciding with a new edge leaves the bit set.
- Start an APB read of 0x00 while in POLL1 -> PREADY stays 0 until POLL2 completes, then data returns correctly.
- Write 0x08 or access 0x18 -> PSLVERR=1, PREADY=1, no strobes; assert PRESETn low during RD1 -> PREADY and rd_port drop at once.
